frac_lut4_cfg_chain: RTL

- Configuration-chain stage directly upstream of the fractured 4-input LUT.
- Serially shifts in one LUT frame: 16 truth-table bits plus the fracture mode bit.
- Holds the frame in a shift register and commits it atomically to shadow registers that drive the LUT's sram/sram_inv/mode/mode_inv inputs.
- Passes the chain on to the next tile through ccff_tail.

---
 rtl/frac_lut4_cfg_chain.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/frac_lut4_cfg_chain.sv
// Serial config chain for the fractured LUT4 with an atomic shadow commit.
// Define FRAC_LUT_CFG_PARITY_EN to add a leading even-parity bit per frame.
module frac_lut4_cfg_chain #(
  parameter int NUM_SRAM = 16,
  parameter int NUM_MODE = 1,
  parameter logic [NUM_MODE-1:0] MODE_RESET = '0
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                ccff_head,
  input  logic                ccff_en,
  output logic                ccff_tail,
  output logic [0:NUM_SRAM-1] sram,
  output logic [0:NUM_SRAM-1] sram_inv,
  output logic [0:NUM_MODE-1] mode,
  output logic [0:NUM_MODE-1] mode_inv,
  output logic                cfg_busy,
  output logic                cfg_commit,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int L = NUM_SRAM + NUM_MODE;
`ifdef FRAC_LUT_CFG_PARITY_EN
  localparam int CL = L + 1;
`else
  localparam int CL = L;
`endif
  localparam int CW = (CL > 1) ? $clog2(CL) : 1;
  localparam logic [CW-1:0] LAST = CW'(CL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CL-1:0]       sh_q, sh_d;
  logic [0:NUM_SRAM-1] sram_q;
  logic [0:NUM_MODE-1] mode_q;
  logic                valid_q;
  logic                par_ok;

  always_comb begin
    sh_d = sh_q;
    if (ccff_en) begin
      sh_d[0] = ccff_head;
      for (int i = 1; i < CL; i++) sh_d[i] = sh_q[i-1];
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // A shift accepted in COMMIT is already bit 1 of the next frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, COMMIT: begin
        if (!ccff_en) begin
          state_d = IDLE;
        end else if (CL == 1) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end else begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (ccff_en) begin
          if (cnt_q == LAST) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cfg_busy   = (state_q == SHIFT);
    cfg_commit = (state_q == COMMIT);
  end

`ifdef FRAC_LUT_CFG_PARITY_EN
  assign par_ok = ~^sh_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sram_q  <= '0;
      for (int j = 0; j < NUM_MODE; j++) mode_q[j] <= MODE_RESET[j];
      valid_q <= 1'b0;
    end else if (cfg_commit && par_ok) begin
      for (int i = 0; i < NUM_SRAM; i++) sram_q[i] <= sh_q[i];
      for (int j = 0; j < NUM_MODE; j++) mode_q[j] <= sh_q[NUM_SRAM+j];
      valid_q <= 1'b1;
    end
  end

`ifdef FRAC_LUT_CFG_PARITY_EN
  logic err_q;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      err_q <= 1'b0;
    end else if (cfg_commit && !par_ok) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  assign ccff_tail = sh_q[CL-1];
  assign sram      = sram_q;
  assign sram_inv  = ~sram_q;
  assign mode      = mode_q;
  assign mode_inv  = ~mode_q;
  assign cfg_valid = valid_q;

endmodule
